// File: rtl/tick_gen.sv
// Free-running timing source for the Tetris game logic.
// Emits independent one-cycle gravity and move-repeat strobes.
module tick_gen #(
    parameter int unsigned VERT_PERIOD  = 50_000_000,
    parameter int unsigned HORIZ_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic vertical_flag,
    output logic horizontal_flag
);

    localparam int unsigned VW = (VERT_PERIOD > 2) ? $clog2(VERT_PERIOD) : 1;
    localparam int unsigned HW = (HORIZ_PERIOD > 2) ? $clog2(HORIZ_PERIOD) : 1;

    localparam logic [VW-1:0] V_LAST = VW'(VERT_PERIOD - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HORIZ_PERIOD - 1);
    localparam logic [VW-1:0] V_ONE  = VW'(1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);

    if (VERT_PERIOD < 2) begin : g_bad_vert
        $error("tick_gen: VERT_PERIOD must be >= 2");
    end
    if (HORIZ_PERIOD < 2) begin : g_bad_horiz
        $error("tick_gen: HORIZ_PERIOD must be >= 2");
    end

    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic          v_flag_q, v_flag_d;
    logic          h_flag_q, h_flag_d;

    // Gravity channel: count to P-1, wrap explicitly and strobe once.
    always_comb begin
        v_cnt_d  = v_cnt_q + V_ONE;
        v_flag_d = 1'b0;
        if (v_cnt_q == V_LAST) begin
            v_cnt_d  = '0;
            v_flag_d = 1'b1;
        end
    end

    // Move-repeat channel: same scheme, fully independent of gravity.
    always_comb begin
        h_cnt_d  = h_cnt_q + H_ONE;
        h_flag_d = 1'b0;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d  = '0;
            h_flag_d = 1'b1;
        end
    end

    // State and strobe registers; reset abandons any period in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_cnt_q  <= '0;
            h_cnt_q  <= '0;
            v_flag_q <= 1'b0;
            h_flag_q <= 1'b0;
        end else begin
            v_cnt_q  <= v_cnt_d;
            h_cnt_q  <= h_cnt_d;
            v_flag_q <= v_flag_d;
            h_flag_q <= h_flag_d;
        end
    end

    assign vertical_flag   = v_flag_q;
    assign horizontal_flag = h_flag_q;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: default, 8/3 and 6/3 period instances.
// Vector table for the 8/3 instance plus hand sequences for the rest.
module tb_tick_gen;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    logic v0, h0, v1, h1, v2, h2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tick_gen u_def (
        .clk(clk), .rst(rst0),
        .vertical_flag(v0), .horizontal_flag(h0)
    );

    tick_gen #(.VERT_PERIOD(8), .HORIZ_PERIOD(3)) u_83 (
        .clk(clk), .rst(rst1),
        .vertical_flag(v1), .horizontal_flag(h1)
    );

    tick_gen #(.VERT_PERIOD(6), .HORIZ_PERIOD(3)) u_63 (
        .clk(clk), .rst(rst2),
        .vertical_flag(v2), .horizontal_flag(h2)
    );

    typedef struct {
        logic r;
        logic v;
        logic h;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx,
                       input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b",
                     name, idx, act, exp);
        end
    endtask

    task automatic add(input string r, input string v, input string h);
        vec_t e;
        for (int i = 0; i < r.len(); i++) begin
            e.r = (r[i] == "1");
            e.v = (v[i] == "1");
            e.h = (h[i] == "1");
            vecs.push_back(e);
        end
    endtask

    initial begin
        // Cadence: 2 reset edges then 24 run edges.
        add({"11", "000000000000000000000000"},
            {"00", "000000010000000100000001"},
            {"00", "001001001001001001001001"});
        // Mid-run reset: 5 run, 2 reset, 9 after release.
        add({"00000", "11", "000000000"},
            {"00000", "00", "000000010"},
            {"00100", "00", "001001001"});
        // Toggle: 5 high, 5 low, then high again.
        add({"11111", "00000", "1111111111"},
            {"00000", "00000", "0000000000"},
            {"00000", "00100", "0000000000"});

        // Default instance: long reset hold.
        @(posedge clk);
        #1;
        for (int i = 0; i < 550; i++) begin
            @(posedge clk);
            #1;
            chk("hold_v", i, v0, 1'b0);
            chk("hold_h", i, h0, 1'b0);
        end
        rst0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("def_run_v", i, v0, 1'b0);
            chk("def_run_h", i, h0, 1'b0);
        end

        // 8/3 instance: table-driven.
        for (int i = 0; i < vecs.size(); i++) begin
            rst1 = vecs[i].r;
            @(posedge clk);
            #1;
            chk("tab_v", i, v1, vecs[i].v);
            chk("tab_h", i, h1, vecs[i].h);
        end

        // 6/3 instance: coincidence.
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        chk("co_rst_v", 0, v2, 1'b0);
        chk("co_rst_h", 0, h2, 1'b0);
        rst2 = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk);
            #1;
            case (k)
                3, 9: begin
                    chk("co_h_only_v", k, v2, 1'b0);
                    chk("co_h_only_h", k, h2, 1'b1);
                end
                6, 12: begin
                    chk("co_both_v", k, v2, 1'b1);
                    chk("co_both_h", k, h2, 1'b1);
                end
                default: begin
                    chk("co_idle_v", k, v2, 1'b0);
                    chk("co_idle_h", k, h2, 1'b0);
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Free-running timing source for the Tetris game logic.
- Produces two independent periodic single-cycle strobes:
  - vertical_flag: gravity tick, which drops the active piece one row.
  - horizontal_flag: left/right move-repeat tick, which paces held-button movement.
- Sits next to the game FSM, which samples each flag as a one-cycle enable. It has no data inputs; periods are fixed by parameters.

Parameters:
- VERT_PERIOD, default 50_000_000: clock cycles between vertical_flag pulses (1 Hz at 50 MHz). Must be >= 2.
- HORIZ_PERIOD, default 5_000_000: clock cycles between horizontal_flag pulses (10 Hz at 50 MHz). Must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- vertical_flag  output  1  one-cycle strobe every VERT_PERIOD cycles.
- horizontal_flag  output  1  one-cycle strobe every HORIZ_PERIOD cycles.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Outputs are registered (driven directly by flops); no combinational path from rst to either output.
- Two independent counters, v_cnt and h_cnt:
  - Width $clog2(PERIOD) each, minimum 1 bit.
  - Unsigned.
  - No shared prescaler.
- Reset: on any rising edge with rst=1:
  - v_cnt=0, h_cnt=0;
  - vertical_flag=0, horizontal_flag=0.
- Reset asserted mid-operation aborts the current period; no pending pulse is emitted later.
- While rst stays high, both flags stay 0 indefinitely.
- Per rising edge with rst=0, for each channel independently (P = its period):
  - if cnt == P-1: cnt <= 0, flag <= 1;
  - else: cnt <= cnt+1, flag <= 0.
- Timing:
  - The first pulse is high during the cycle after the P-th rising edge following reset deassertion.
  - The first edge with rst=0 counts as edge 1.
  - Subsequent pulses repeat exactly every P cycles.
  - Each pulse lasts exactly one clock cycle; the flag is never high on consecutive cycles (P >= 2).
- Counter wrap: the counter never exceeds P-1; wrap is explicit, not natural overflow.
- Simultaneous events: both flags may assert in the same cycle (when elapsed cycles is a common multiple of both periods). No priority or suppression between them.
- No enable, no pause input. Period changes require re-elaboration.
- Illegal parameters (P < 2) are rejected at elaboration via an assertion or $error.
- X-free after the first reset edge; no initial-value reliance for synthesis.

Test Plan:
- Reset hold: rst=1 for 550 cycles (defaults) -> vertical_flag=0 and horizontal_flag=0 every cycle.
- Vertical cadence (VERT_PERIOD=8, HORIZ_PERIOD=3): deassert rst, count edges -> vertical_flag high only in the cycle after edges 8, 16, 24, ...; width exactly 1 cycle; 0 elsewhere.
- Horizontal cadence (same overrides) -> horizontal_flag high after edges 3, 6, 9, 12, ...; 0 on all other cycles.
- Coincidence (VERT_PERIOD=6, HORIZ_PERIOD=3) -> after edge 6 both flags high in the same cycle; after edge 3 only horizontal_flag high.
- Mid-run reset (VERT_PERIOD=8, HORIZ_PERIOD=3):
  - run 5 cycles, assert rst for 2 cycles, release;
  - no pulse during reset;
  - next vertical pulse after edge 8 counted from release; horizontal after edge 3.
- Reset toggle sequence: rst=1 for 5 cycles, 0 for 5 cycles, 1 thereafter (VERT_PERIOD=8, HORIZ_PERIOD=3):
  - horizontal_flag pulses once (after edge 3 of the low window);
  - vertical_flag never pulses;
  - both stay 0 once rst is high again.
